phs_flow_tracker: RTL and testbench

//  Downstream of the N6 packet parser. Accepts the 120-bit PHS tuple on its single-cycle valid pulse.

---
 rtl/phs_flow_tracker_pkg.sv | 50 +++++
 rtl/phs_flow_tracker_fifo.sv | 55 +++++
 rtl/phs_flow_tracker.sv | 182 ++++++++++++++++++
 tb/tb_phs_flow_tracker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/phs_flow_tracker_pkg.sv
// Shared types for the PHS flow tracker: tuple layout, 5-tuple flow key, FSM states.
package phs_flow_tracker_pkg;

   localparam int         PHS_W       = 120;
   localparam int         KEY_W       = 104;
   localparam int         PHS_TAG_MSB = 119;
   localparam int         PHS_TAG_LSB = 112;
   localparam logic [7:0] PHS_TAG     = 8'h06;

   // Field order mirrors the bit layout, tag in the top byte.
   typedef struct packed {
      logic [7:0]  tag;
      logic [7:0]  tos;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [7:0]  proto;
      logic [31:0] sip;
      logic [31:0] dip;
   } phs_t;

   typedef struct packed {
      logic [31:0] sip;
      logic [31:0] dip;
      logic [15:0] sport;
      logic [15:0] dport;
      logic [7:0]  proto;
   } flow_key_t;

   typedef enum logic [1:0] {
      FT_IDLE   = 2'd0,
      FT_LOOKUP = 2'd1,
      FT_UPDATE = 2'd2,
      FT_EMIT   = 2'd3
   } ft_state_t;

   function automatic flow_key_t phs_to_key(input phs_t p);
      flow_key_t k;
      k.sip   = p.sip;
      k.dip   = p.dip;
      k.sport = p.sport;
      k.dport = p.dport;
      k.proto = p.proto;
      return k;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/phs_flow_tracker_fifo.sv
// Synchronous FIFO for PHS tuples; push is ignored when full, pop ignored when empty.
// Read data is the current head (combinational), count/full/empty are registered.
module phs_flow_tracker_fifo #(
   parameter int WIDTH = 120,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   import phs_flow_tracker_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   always_ff @(posedge CLK) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/phs_flow_tracker.sv
// Buffers PHS tuples, matches their 5-tuple in a fully-associative flow table, emits id/new/evict/count.
// Result valid 3 edges after push into an idle tracker; input has no backpressure (drops when full), output is valid/ready.
module phs_flow_tracker #(
   parameter int NUM_FLOWS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic [119:0]                 phs_i,
   input  logic                         phs_valid_i,
   input  logic                         out_ready_i,
   output logic                         out_valid_o,
   output logic [$clog2(NUM_FLOWS)-1:0] flow_id_o,
   output logic                         flow_new_o,
   output logic                         flow_evict_o,
   output logic [CNT_W-1:0]             pkt_cnt_o,
   output logic [15:0]                  drop_cnt_o,
   output logic [15:0]                  bad_tag_cnt_o
);
   import phs_flow_tracker_pkg::*;

   localparam int IDW = $clog2(NUM_FLOWS);

   ft_state_t                 state_q, state_d;
   logic                      tag_ok, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic                      tuple_drop, tuple_bad;
   logic [PHS_W-1:0]          fifo_dat;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   phs_t                      head;
   logic                      unused_fifo;

   logic [15:0]               drop_cnt_q, bad_tag_cnt_q;
   flow_key_t                 key_q;
   logic [NUM_FLOWS-1:0]      valid_q;
   flow_key_t                 tbl_key_q [NUM_FLOWS];
   logic [CNT_W-1:0]          tbl_cnt_q [NUM_FLOWS];
   logic [IDW-1:0]            rr_q;
   logic                      hit_q;
   logic [IDW-1:0]            hit_idx_q;

   logic                      hit_any, free_vld;
   logic [IDW-1:0]            hit_idx, free_idx;
   logic [IDW-1:0]            upd_idx;
   logic                      upd_new, upd_evict;
   logic [CNT_W-1:0]          upd_cnt, cur_cnt;

   logic [IDW-1:0]            out_id_q;
   logic                      out_new_q, out_evict_q;
   logic [CNT_W-1:0]          out_cnt_q;

   // Bad tag is checked before fullness so a malformed tuple never counts as a drop.
   assign tag_ok     = (phs_i[PHS_TAG_MSB:PHS_TAG_LSB] == PHS_TAG);
   assign tuple_bad  = phs_valid_i && !tag_ok;
   assign tuple_drop = phs_valid_i && tag_ok && fifo_full;
   assign fifo_push  = phs_valid_i && tag_ok && !fifo_full;

   phs_flow_tracker_fifo #(
      .WIDTH (PHS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK        (CLK),
      .reset      (reset),
      .push_i     (fifo_push),
      .push_dat_i (phs_i),
      .pop_i      (fifo_pop),
      .pop_dat_o  (fifo_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign head        = fifo_dat;
   assign unused_fifo = ^{head.tag, head.tos, fifo_count};

   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      case (state_q)
         FT_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = FT_LOOKUP;
            end
         end
         FT_LOOKUP: state_d = FT_UPDATE;
         FT_UPDATE: state_d = FT_EMIT;
         FT_EMIT:   if (out_ready_i) state_d = FT_IDLE;
         default:   state_d = FT_IDLE;
      endcase
   end

   // Lowest-index match wins; a key is never held in two valid entries anyway.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = NUM_FLOWS-1; i >= 0; i--) begin
         if (valid_q[i] && (tbl_key_q[i] == key_q)) begin
            hit_any = 1'b1;
            hit_idx = IDW'(i);
         end
      end
   end

   always_comb begin
      free_vld = 1'b0;
      free_idx = '0;
      for (int i = NUM_FLOWS-1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_vld = 1'b1;
            free_idx = IDW'(i);
         end
      end
   end

   always_comb begin
      cur_cnt   = tbl_cnt_q[hit_idx_q];
      upd_idx   = hit_idx_q;
      upd_new   = 1'b0;
      upd_evict = 1'b0;
      upd_cnt   = (&cur_cnt) ? cur_cnt : cur_cnt + 1'b1;
      if (!hit_q) begin
         upd_new = 1'b1;
         upd_cnt = CNT_W'(1);
         if (free_vld) begin
            upd_idx = free_idx;
         end else begin
            upd_idx   = rr_q;
            upd_evict = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q       <= FT_IDLE;
         drop_cnt_q    <= '0;
         bad_tag_cnt_q <= '0;
         valid_q       <= '0;
         rr_q          <= '0;
         hit_q         <= 1'b0;
         hit_idx_q     <= '0;
         out_id_q      <= '0;
         out_new_q     <= 1'b0;
         out_evict_q   <= 1'b0;
         out_cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (tuple_drop) drop_cnt_q    <= sat_inc16(drop_cnt_q);
         if (tuple_bad)  bad_tag_cnt_q <= sat_inc16(bad_tag_cnt_q);
         if (state_q == FT_LOOKUP) begin
            hit_q     <= hit_any;
            hit_idx_q <= hit_idx;
         end
         if (state_q == FT_UPDATE) begin
            valid_q[upd_idx] <= 1'b1;
            out_id_q         <= upd_idx;
            out_new_q        <= upd_new;
            out_evict_q      <= upd_evict;
            out_cnt_q        <= upd_cnt;
            if (upd_evict) rr_q <= rr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (fifo_pop) key_q <= phs_to_key(head);
      if (state_q == FT_UPDATE) begin
         tbl_key_q[upd_idx] <= key_q;
         tbl_cnt_q[upd_idx] <= upd_cnt;
      end
   end

   assign out_valid_o   = (state_q == FT_EMIT);
   assign flow_id_o     = out_id_q;
   assign flow_new_o    = out_new_q;
   assign flow_evict_o  = out_evict_q;
   assign pkt_cnt_o     = out_cnt_q;
   assign drop_cnt_o    = drop_cnt_q;
   assign bad_tag_cnt_o = bad_tag_cnt_q;

endmodule

// File: tb/tb_phs_flow_tracker.sv
// Directed scoreboard bench for phs_flow_tracker: expected results queued at issue, checked by a monitor.
module tb_phs_flow_tracker;

   logic         CLK = 1'b0;
   logic         reset;
   logic [119:0] phs_i;
   logic         phs_valid_i;
   logic         out_ready_i;
   logic         out_valid_o;
   logic [2:0]   flow_id_o;
   logic         flow_new_o;
   logic         flow_evict_o;
   logic [15:0]  pkt_cnt_o;
   logic [15:0]  drop_cnt_o;
   logic [15:0]  bad_tag_cnt_o;

   typedef struct packed {
      logic [2:0]  id;
      logic        nw;
      logic        ev;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_res  = 0;

   always #5 CLK = ~CLK;

   phs_flow_tracker #(.NUM_FLOWS(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .phs_i         (phs_i),
      .phs_valid_i   (phs_valid_i),
      .out_ready_i   (out_ready_i),
      .out_valid_o   (out_valid_o),
      .flow_id_o     (flow_id_o),
      .flow_new_o    (flow_new_o),
      .flow_evict_o  (flow_evict_o),
      .pkt_cnt_o     (pkt_cnt_o),
      .drop_cnt_o    (drop_cnt_o),
      .bad_tag_cnt_o (bad_tag_cnt_o)
   );

   function automatic logic [119:0] mk(input logic [31:0] sip, input logic [31:0] dip,
                                       input logic [15:0] sport, input logic [15:0] dport,
                                       input logic [7:0] proto, input logic [7:0] tos,
                                       input logic [7:0] tag);
      return {tag, tos, sport, dport, proto, sip, dip};
   endfunction

   function automatic exp_t ex(input int id, input bit nw, input bit ev, input int cnt);
      exp_t e;
      e.id  = 3'(id);
      e.nw  = nw;
      e.ev  = ev;
      e.cnt = 16'(cnt);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every accepted result must match the head of the scoreboard.
   initial begin
      exp_t e;
      exp_t act;
      forever begin
         @(negedge CLK);
         if (!reset && out_valid_o && out_ready_i) begin
            act = {flow_id_o, flow_new_o, flow_evict_o, pkt_cnt_o};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got id=%0d new=%0b evict=%0b cnt=%0d, expected none",
                        flow_id_o, flow_new_o, flow_evict_o, pkt_cnt_o);
            end else begin
               e = exp_q.pop_front();
               n_res++;
               check($sformatf("result%0d{id,new,evict,cnt}", n_res), 32'(act), 32'(e));
            end
         end
      end
   end

   task automatic send(input logic [119:0] t, input bit expect_out, input exp_t e);
      phs_i       = t;
      phs_valid_i = 1'b1;
      if (expect_out) exp_q.push_back(e);
      @(posedge CLK);
      #1;
      phs_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge CLK);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      @(posedge CLK);
      #1;
      reset = 1'b0;
   endtask

   logic [119:0] t1;

   initial begin
      reset       = 1'b1;
      phs_i       = '0;
      phs_valid_i = 1'b0;
      out_ready_i = 1'b1;
      t1          = mk(32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 8'h11, 8'h00, 8'h06);
      repeat (2) @(posedge CLK);
      #1;
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_outputs", 32'({flow_id_o, flow_new_o, flow_evict_o, pkt_cnt_o}), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
      check("rst_bad_tag_cnt", 32'(bad_tag_cnt_o), 32'd0);
      reset = 1'b0;
      @(posedge CLK);
      #1;

      // First tuple: result appears exactly after the third edge following the push.
      send(t1, 1'b1, ex(0, 1, 0, 1));
      repeat (2) @(posedge CLK);
      #1;
      check("latency_t+2_valid", 32'(out_valid_o), 32'd0);
      @(posedge CLK);
      #1;
      check("latency_t+3_valid", 32'(out_valid_o), 32'd1);
      drain();

      // TOS is not part of the key; a different dPort is a new flow.
      send(mk(32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 8'h11, 8'h5C, 8'h06), 1'b1, ex(0, 0, 0, 2));
      drain();
      send(mk(32'h0A000001, 32'h0A000002, 16'h1234, 16'h0051, 8'h11, 8'h00, 8'h06), 1'b1, ex(1, 1, 0, 1));
      drain();
      send(t1, 1'b1, ex(0, 0, 0, 3));
      drain();

      // Fill the table, then evict round-robin from entry 0.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(mk(32'hC0A80000 + 32'(i), 32'h08080808, 16'd1000, 16'd53, 8'h11, 8'h00, 8'h06),
              1'b1, ex(i, 1, 0, 1));
         drain();
      end
      send(mk(32'hAC100001, 32'h08080808, 16'd1000, 16'd53, 8'h11, 8'h00, 8'h06), 1'b1, ex(0, 1, 1, 1));
      drain();
      send(mk(32'hAC100002, 32'h08080808, 16'd1000, 16'd53, 8'h11, 8'h00, 8'h06), 1'b1, ex(1, 1, 1, 1));
      drain();
      send(mk(32'hC0A80002, 32'h08080808, 16'd1000, 16'd53, 8'h11, 8'h00, 8'h06), 1'b1, ex(2, 0, 0, 2));
      drain();

      // Stalled consumer: one tuple in the FSM, four in the FIFO, the sixth dropped.
      do_reset();
      out_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(mk(32'h0A0A0A0A, 32'h0B0B0B0B, 16'd7, 16'h0100 + 16'(i), 8'h06, 8'h00, 8'h06),
              (i < 5), ex(i, 1, 0, 1));
      end
      // Bad tag while FIFO is full counts as bad tag, not as a drop.
      send(mk(32'h0A0A0A0A, 32'h0B0B0B0B, 16'd7, 16'h0200, 8'h06, 8'h00, 8'h00), 1'b0, ex(0, 0, 0, 0));
      check("stall_out_valid", 32'(out_valid_o), 32'd1);
      check("full_drop_cnt", 32'(drop_cnt_o), 32'd1);
      check("full_bad_tag_cnt", 32'(bad_tag_cnt_o), 32'd1);
      out_ready_i = 1'b1;
      drain();

      // Bad tag into an empty FIFO produces nothing.
      send(mk(32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 8'h11, 8'h00, 8'h00), 1'b0, ex(0, 0, 0, 0));
      repeat (8) @(posedge CLK);
      #1;
      check("badtag_cnt", 32'(bad_tag_cnt_o), 32'd2);
      check("badtag_no_valid", 32'(out_valid_o), 32'd0);
      check("badtag_drop_cnt", 32'(drop_cnt_o), 32'd1);

      // Reset while a result is being presented aborts it.
      out_ready_i = 1'b0;
      send(t1, 1'b1, ex(5, 1, 0, 1));
      repeat (3) @(posedge CLK);
      #1;
      check("emit_valid", 32'(out_valid_o), 32'd1);
      check("emit_id", 32'(flow_id_o), 32'd5);
      do_reset();
      check("abort_out_valid", 32'(out_valid_o), 32'd0);
      check("abort_drop_cnt", 32'(drop_cnt_o), 32'd0);
      check("abort_bad_tag_cnt", 32'(bad_tag_cnt_o), 32'd0);
      check("abort_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
      repeat (6) @(posedge CLK);
      #1;
      check("abort_stays_idle", 32'(out_valid_o), 32'd0);
      out_ready_i = 1'b1;
      send(t1, 1'b1, ex(0, 1, 0, 1));
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t, expected to finish earlier", $time);
      $fatal(1, "timeout");
   end

endmodule
